// File: rtl/spi_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spi_seq_pkg                                             |
// | Brief    : Shared op encodings, sequencer states, entry width.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package spi_seq_pkg;

    localparam logic [1:0] OP_SEND = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_SKIP = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_FRAME = 3'd2,
        SEQ_WAIT  = 3'd3,
        SEQ_SKIP  = 3'd4
    } seq_state_e;

    // Table entry = 2-bit op on top of a full frame payload.
    function automatic int entry_w(input int frame_w);
        return frame_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_frame_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spi_frame_shifter                                       |
// | Brief    : One SPI mode-0 frame, MSB first, with CS setup/hold/gap.|
// |            Optional readback when SPI_READBACK_EN is defined.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module spi_frame_shifter
    import spi_seq_pkg::*;
#(
    parameter int FRAME_W = 40,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] data,
    output logic               done,
    output logic               sclk,
    output logic               cs_n,
    output logic               mosi
`ifdef SPI_READBACK_EN
    ,
    input  logic               miso,
    output logic [FRAME_W-1:0] rd_data,
    output logic               rd_valid
`endif
);

    localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [2:0] c_PH_IDLE  = 3'd0;
    localparam logic [2:0] c_PH_SETUP = 3'd1;
    localparam logic [2:0] c_PH_SHIFT = 3'd2;
    localparam logic [2:0] c_PH_HOLD  = 3'd3;
    localparam logic [2:0] c_PH_GAP   = 3'd4;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(CS_GAP - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_W - 1);
    localparam logic [2:0]         c_PH_AFTER_HOLD = (CS_GAP == 0) ? c_PH_IDLE : c_PH_GAP;

    logic [2:0]         r_phase;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BIT_W-1:0] r_bit;
    logic [FRAME_W-1:0] r_sreg;
    logic               r_sclk;
    logic               r_cs_n;
    logic               r_mosi;
    logic               w_div_end;
    logic               w_hold_end;

    assign w_div_end  = (r_cnt == c_DIV_LAST);
    assign w_hold_end = (r_phase == c_PH_HOLD) && w_div_end;
    assign done       = (CS_GAP == 0) ? w_hold_end
                                      : ((r_phase == c_PH_GAP) && (r_cnt == c_GAP_LAST));
    assign sclk       = r_sclk;
    assign cs_n       = r_cs_n;
    assign mosi       = r_mosi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= c_PH_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sreg  <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            case (r_phase)
                c_PH_IDLE: begin
                    if (start) begin
                        r_phase <= c_PH_SETUP;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sreg  <= data;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= data[FRAME_W-1];
                    end
                end
                c_PH_SETUP: begin
                    r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                    if (w_div_end) begin
                        r_phase <= c_PH_SHIFT;
                        r_sclk  <= 1'b1;
                    end
                end
                c_PH_SHIFT: begin
                    r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                    if (w_div_end) begin
                        if (r_sclk) begin
                            // Falling edge: present the next bit, the last bit stays through hold.
                            r_sclk <= 1'b0;
                            if (r_bit != c_BIT_LAST) begin
                                r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
                                r_mosi <= r_sreg[FRAME_W-2];
                            end
                        end else if (r_bit == c_BIT_LAST) begin
                            r_phase <= c_PH_HOLD;
                        end else begin
                            r_sclk <= 1'b1;
                            r_bit  <= r_bit + 1'b1;
                        end
                    end
                end
                c_PH_HOLD: begin
                    r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                    if (w_div_end) begin
                        r_phase <= c_PH_AFTER_HOLD;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                    end
                end
                c_PH_GAP: begin
                    if (done) begin
                        r_phase <= c_PH_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_phase <= c_PH_IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    localparam logic [c_CNT_W-1:0] c_DIV_PEN = (CLK_DIV > 1) ? c_CNT_W'(CLK_DIV - 2)
                                                             : {c_CNT_W{1'b0}};

    logic [FRAME_W-1:0] r_rx;
    logic [FRAME_W-1:0] r_rd_data;
    logic               r_rd_valid;
    logic               w_rise;
    logic               w_hold_entry;
    logic               w_last_hold;

    // Edges of clk that raise sclk are exactly the points where miso is sampled.
    assign w_rise       = ((r_phase == c_PH_SETUP) && w_div_end)
                       || ((r_phase == c_PH_SHIFT) && w_div_end && !r_sclk && (r_bit != c_BIT_LAST));
    assign w_hold_entry = (r_phase == c_PH_SHIFT) && w_div_end && !r_sclk && (r_bit == c_BIT_LAST);
    assign w_last_hold  = (CLK_DIV == 1) ? w_hold_entry
                                         : ((r_phase == c_PH_HOLD) && (r_cnt == c_DIV_PEN));
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_rise) begin
                r_rx <= {r_rx[FRAME_W-2:0], miso};
            end
            r_rd_valid <= w_last_hold;
            if (w_last_hold) begin
                r_rd_data <= r_rx;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : spi_cmd_sequencer                                       |
// | Brief    : SPI command master playing a SEND/WAIT/SKIP/END table   |
// |            or single host frames. Readback via SPI_READBACK_EN.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FRAME_W  = 40,
    parameter int CONF_LEN = 22,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 7,
    parameter int WAIT_W   = 17
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  init_start,
    input  logic                                  wr_start,
    input  logic [FRAME_W-1:0]                    wr_data,
    input  logic [CONF_LEN*entry_w(FRAME_W)-1:0]  init_table,
    output logic                                  busy,
    output logic                                  init_done,
    output logic                                  sclk,
    output logic                                  cs_n,
    output logic                                  mosi
`ifdef SPI_READBACK_EN
    ,
    input  logic                                  miso,
    output logic [FRAME_W-1:0]                    rd_data,
    output logic                                  rd_valid
`endif
);

    localparam int c_ENTRY_W = entry_w(FRAME_W);
    localparam int c_IDX_W   = (CONF_LEN > 1) ? $clog2(CONF_LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(CONF_LEN - 1);

    seq_state_e           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_last_entry;
    logic                 r_wr_mode;
    logic                 r_busy;
    logic                 r_init_done;
    logic [WAIT_W-1:0]    r_wait_cnt;

    logic [c_ENTRY_W-1:0] w_entry;
    logic [1:0]           w_op;
    logic [FRAME_W-1:0]   w_payload;
    logic                 w_accept_init;
    logic                 w_accept_wr;
    logic                 w_frame_start;
    logic [FRAME_W-1:0]   w_frame_data;
    logic                 w_frame_done;
    logic                 w_entry_end;

    assign w_entry       = init_table[r_idx * c_ENTRY_W +: c_ENTRY_W];
    assign w_op          = w_entry[c_ENTRY_W-1 -: 2];
    assign w_payload     = w_entry[FRAME_W-1:0];
    // init_start has priority; a simultaneous wr_start is dropped.
    assign w_accept_init = (r_state == SEQ_IDLE) && init_start;
    assign w_accept_wr   = (r_state == SEQ_IDLE) && wr_start && !init_start;
    assign w_frame_start = w_accept_wr || ((r_state == SEQ_FETCH) && (w_op == OP_SEND));
    assign w_frame_data  = (r_state == SEQ_FETCH) ? w_payload : wr_data;
    assign w_entry_end   = ((r_state == SEQ_FRAME) && w_frame_done)
                        || ((r_state == SEQ_WAIT) && (r_wait_cnt == '0))
                        ||  (r_state == SEQ_SKIP);
    assign busy          = r_busy;
    assign init_done     = r_init_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SEQ_IDLE;
            r_idx        <= '0;
            r_last_entry <= 1'b0;
            r_wr_mode    <= 1'b0;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (w_accept_init) begin
                        r_state     <= SEQ_FETCH;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_init_done <= 1'b0;
                        r_wr_mode   <= 1'b0;
                    end else if (w_accept_wr) begin
                        r_state   <= SEQ_FRAME;
                        r_busy    <= 1'b1;
                        r_wr_mode <= 1'b1;
                    end
                end
                SEQ_FETCH: begin
                    r_last_entry <= (r_idx == c_IDX_LAST);
                    r_idx        <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    case (w_op)
                        OP_SEND: r_state <= SEQ_FRAME;
                        OP_WAIT: begin
                            r_state    <= SEQ_WAIT;
                            r_wait_cnt <= w_payload[WAIT_W-1:0];
                        end
                        OP_SKIP: r_state <= SEQ_SKIP;
                        default: begin
                            r_state     <= SEQ_IDLE;
                            r_busy      <= 1'b0;
                            r_init_done <= 1'b1;
                        end
                    endcase
                end
                SEQ_FRAME, SEQ_WAIT, SEQ_SKIP: begin
                    if ((r_state == SEQ_WAIT) && (r_wait_cnt != '0)) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                    if (w_entry_end) begin
                        if (r_wr_mode) begin
                            r_state <= SEQ_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_last_entry) begin
                            r_state     <= SEQ_IDLE;
                            r_busy      <= 1'b0;
                            r_init_done <= 1'b1;
                        end else begin
                            r_state <= SEQ_FETCH;
                        end
                    end
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

    spi_frame_shifter #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (w_frame_start),
        .data     (w_frame_data),
        .done     (w_frame_done),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi)
`ifdef SPI_READBACK_EN
        ,
        .miso     (miso),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`endif
    );

endmodule
`default_nettype wire
